// File: rtl/ysyx_24090003_mem_arbiter_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter: FSM states, owner tags
// and the data word returned when a transaction times out.
package ysyx_24090003_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2,
    ARB_RESP = 2'd3
  } arb_state_e;

  localparam logic ARB_OWN_IFU = 1'b0;
  localparam logic ARB_OWN_LSU = 1'b1;

  localparam logic [31:0] ARB_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/ysyx_24090003_arb_timer.sv
// Response timeout counter: cleared when a request is accepted, counts while
// a transaction is outstanding, flags expiry on its LIMIT-th busy cycle.
module ysyx_24090003_arb_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired_c
);

  localparam int unsigned CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q;

  assign o_expired_c = i_en && (cnt_q == CNT_W'(LIMIT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      cnt_q <= '0;
    end else if (i_en && !o_expired_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ysyx_24090003_mem_arbiter.sv
// Merges IFU fetch and LSU data ports onto one memory port, one transaction at
// a time, LSU first. Optional timeout via YSYX_24090003_ARB_TIMEOUT_EN.
module ysyx_24090003_mem_arbiter
  import ysyx_24090003_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_ifu_valid,
  output logic                o_ifu_ready,
  input  logic [ADDR_W-1:0]   i_ifu_addr,
  output logic                o_ifu_rvalid,
  output logic [DATA_W-1:0]   o_ifu_rdata,
  input  logic                i_lsu_valid,
  output logic                o_lsu_ready,
  input  logic [ADDR_W-1:0]   i_lsu_addr,
  input  logic                i_lsu_we,
  input  logic [DATA_W-1:0]   i_lsu_wdata,
  input  logic [DATA_W/8-1:0] i_lsu_wmask,
  output logic                o_lsu_rvalid,
  output logic [DATA_W-1:0]   o_lsu_rdata,
  output logic                o_mem_valid,
  input  logic                i_mem_ready,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic                o_mem_we,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_wmask,
  input  logic                i_mem_rvalid,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_err
);

  localparam int unsigned MASK_W = DATA_W / 8;

  if (TIMEOUT_CYCLES == 0) begin : g_cfg_check
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  arb_state_e          state_q;
  logic                owner_q;
  logic                mem_valid_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   wmask_q;
  logic                ifu_rvalid_q;
  logic                lsu_rvalid_q;
  logic [DATA_W-1:0]   ifu_rdata_q;
  logic [DATA_W-1:0]   lsu_rdata_q;
  logic                err_q;

  logic                timeout_hit_c;
  logic                resp_fire_c;
  logic                resp_err_c;
  logic [DATA_W-1:0]   resp_data_c;

  // Grants exist only in IDLE; LSU wins ties.
  assign o_lsu_ready = (state_q == ARB_IDLE) && i_lsu_valid;
  assign o_ifu_ready = (state_q == ARB_IDLE) && i_ifu_valid && !i_lsu_valid;

`ifdef YSYX_24090003_ARB_TIMEOUT_EN
  logic tmr_expired_c;

  ysyx_24090003_arb_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (o_ifu_ready || o_lsu_ready),
    .i_en       ((state_q == ARB_REQ) || (state_q == ARB_WAIT)),
    .o_expired_c(tmr_expired_c)
  );

  assign timeout_hit_c = tmr_expired_c;
`else
  assign timeout_hit_c = 1'b0;
`endif

  // A real response in WAIT beats a timeout expiring on the same cycle.
  always_comb begin
    resp_fire_c = 1'b0;
    resp_err_c  = 1'b0;
    resp_data_c = '0;
    if ((state_q == ARB_WAIT) && i_mem_rvalid) begin
      resp_fire_c = 1'b1;
      resp_data_c = we_q ? '0 : i_mem_rdata;
    end else if (((state_q == ARB_REQ) || (state_q == ARB_WAIT)) && timeout_hit_c) begin
      resp_fire_c = 1'b1;
      resp_err_c  = 1'b1;
      resp_data_c = DATA_W'(ARB_ERR_DATA);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= ARB_OWN_IFU;
      mem_valid_q  <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      ifu_rvalid_q <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      ifu_rdata_q  <= '0;
      lsu_rdata_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      ifu_rvalid_q <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      if (resp_fire_c) begin
        state_q     <= ARB_RESP;
        mem_valid_q <= 1'b0;
        err_q       <= err_q || resp_err_c;
        if (owner_q == ARB_OWN_LSU) begin
          lsu_rvalid_q <= 1'b1;
          lsu_rdata_q  <= resp_data_c;
        end else begin
          ifu_rvalid_q <= 1'b1;
          ifu_rdata_q  <= resp_data_c;
        end
      end else begin
        unique case (state_q)
          ARB_IDLE: begin
            if (o_lsu_ready) begin
              owner_q     <= ARB_OWN_LSU;
              addr_q      <= i_lsu_addr;
              we_q        <= i_lsu_we;
              wdata_q     <= i_lsu_wdata;
              wmask_q     <= i_lsu_wmask;
              mem_valid_q <= 1'b1;
              state_q     <= ARB_REQ;
            end else if (o_ifu_ready) begin
              owner_q     <= ARB_OWN_IFU;
              addr_q      <= i_ifu_addr;
              we_q        <= 1'b0;
              wdata_q     <= '0;
              wmask_q     <= '0;
              mem_valid_q <= 1'b1;
              state_q     <= ARB_REQ;
            end
          end
          ARB_REQ: begin
            if (i_mem_ready) begin
              mem_valid_q <= 1'b0;
              state_q     <= ARB_WAIT;
            end
          end
          ARB_WAIT: state_q <= ARB_WAIT;
          ARB_RESP: state_q <= ARB_IDLE;
          default:  state_q <= ARB_IDLE;
        endcase
      end
    end
  end

  assign o_mem_valid  = mem_valid_q;
  assign o_mem_addr   = addr_q;
  assign o_mem_we     = we_q;
  assign o_mem_wdata  = wdata_q;
  assign o_mem_wmask  = wmask_q;
  assign o_ifu_rvalid = ifu_rvalid_q;
  assign o_ifu_rdata  = ifu_rdata_q;
  assign o_lsu_rvalid = lsu_rvalid_q;
  assign o_lsu_rdata  = lsu_rdata_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_ysyx_24090003_mem_arbiter.sv
// Directed self-checking bench for ysyx_24090003_mem_arbiter; inputs change
// and outputs are sampled on the falling clock edge.
module tb_ysyx_24090003_mem_arbiter;

  localparam int unsigned TB_TIMEOUT = 4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_ifu_valid;
  logic        o_ifu_ready;
  logic [31:0] i_ifu_addr;
  logic        o_ifu_rvalid;
  logic [31:0] o_ifu_rdata;
  logic        i_lsu_valid;
  logic        o_lsu_ready;
  logic [31:0] i_lsu_addr;
  logic        i_lsu_we;
  logic [31:0] i_lsu_wdata;
  logic [3:0]  i_lsu_wmask;
  logic        o_lsu_rvalid;
  logic [31:0] o_lsu_rdata;
  logic        o_mem_valid;
  logic        i_mem_ready;
  logic [31:0] o_mem_addr;
  logic        o_mem_we;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wmask;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 i_clk = ~i_clk;

  ysyx_24090003_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_ifu_valid(i_ifu_valid), .o_ifu_ready(o_ifu_ready), .i_ifu_addr(i_ifu_addr),
    .o_ifu_rvalid(o_ifu_rvalid), .o_ifu_rdata(o_ifu_rdata),
    .i_lsu_valid(i_lsu_valid), .o_lsu_ready(o_lsu_ready), .i_lsu_addr(i_lsu_addr),
    .i_lsu_we(i_lsu_we), .i_lsu_wdata(i_lsu_wdata), .i_lsu_wmask(i_lsu_wmask),
    .o_lsu_rvalid(o_lsu_rvalid), .o_lsu_rdata(o_lsu_rdata),
    .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr),
    .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata), .o_mem_wmask(o_mem_wmask),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata), .o_err(o_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge i_clk);
  endtask

  // Called in REQ: stall, accept, then respond; returns at the RESP cycle.
  task automatic mem_txn(input string tag, input int stall, input bit noise,
                         input logic [31:0] rdata, input logic [31:0] eaddr,
                         input logic ewe, input logic [31:0] ewdata, input logic [3:0] emask);
    for (int i = 0; i <= stall; i++) begin
      chk({tag, "_mvalid"}, 64'(o_mem_valid), 64'd1);
      chk({tag, "_maddr"},  64'(o_mem_addr), 64'(eaddr));
      chk({tag, "_mwe"},    64'(o_mem_we), 64'(ewe));
      chk({tag, "_mmask"},  64'(o_mem_wmask), 64'(emask));
      if (ewe) chk({tag, "_mwdata"}, 64'(o_mem_wdata), 64'(ewdata));
      chk({tag, "_ready_busy"}, 64'({o_ifu_ready, o_lsu_ready}), 64'd0);
      i_mem_ready  = (i == stall);
      i_mem_rvalid = noise;
      i_mem_rdata  = 32'hBAD0BAD0;
      step();
    end
    i_mem_ready = 1'b0;
    chk({tag, "_wait_mvalid"}, 64'(o_mem_valid), 64'd0);
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = rdata;
    step();
    i_mem_rvalid = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1;
    i_ifu_valid = 1'b0; i_ifu_addr = '0;
    i_lsu_valid = 1'b0; i_lsu_addr = '0; i_lsu_we = 1'b0;
    i_lsu_wdata = '0; i_lsu_wmask = '0;
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    repeat (2) step();
    chk("rst_mvalid", 64'(o_mem_valid), 64'd0);
    chk("rst_rvalids", 64'({o_ifu_rvalid, o_lsu_rvalid}), 64'd0);
    chk("rst_rdata", 64'({o_ifu_rdata, o_lsu_rdata}), 64'd0);
    chk("rst_err", 64'(o_err), 64'd0);
    i_rst = 1'b0;
    step();

    // IFU-only read
    i_ifu_valid = 1'b1; i_ifu_addr = 32'h8000_0000;
    #1;
    chk("t1_ifu_ready", 64'(o_ifu_ready), 64'd1);
    chk("t1_lsu_ready", 64'(o_lsu_ready), 64'd0);
    step();
    i_ifu_valid = 1'b0;
    mem_txn("t1", 0, 1'b0, 32'h0000_0413, 32'h8000_0000, 1'b0, 32'h0, 4'h0);
    chk("t1_ifu_rvalid", 64'(o_ifu_rvalid), 64'd1);
    chk("t1_ifu_rdata", 64'(o_ifu_rdata), 64'h413);
    chk("t1_lsu_rvalid", 64'(o_lsu_rvalid), 64'd0);
    step();
    chk("t1_pulse_end", 64'(o_ifu_rvalid), 64'd0);
    chk("t1_rdata_hold", 64'(o_ifu_rdata), 64'h413);

    // Simultaneous requests: LSU first, IFU held until the next IDLE
    i_ifu_valid = 1'b1; i_ifu_addr = 32'h8000_0004;
    i_lsu_valid = 1'b1; i_lsu_addr = 32'h8000_1000; i_lsu_we = 1'b0; i_lsu_wmask = 4'h0;
    #1;
    chk("t2_lsu_ready", 64'(o_lsu_ready), 64'd1);
    chk("t2_ifu_ready", 64'(o_ifu_ready), 64'd0);
    step();
    i_lsu_valid = 1'b0;
    mem_txn("t2a", 0, 1'b0, 32'h1234_5678, 32'h8000_1000, 1'b0, 32'h0, 4'h0);
    chk("t2_lsu_rvalid", 64'(o_lsu_rvalid), 64'd1);
    chk("t2_lsu_rdata", 64'(o_lsu_rdata), 64'h1234_5678);
    chk("t2_ifu_quiet", 64'(o_ifu_rvalid), 64'd0);
    chk("t2_resp_ready", 64'(o_ifu_ready), 64'd0);
    step();
    chk("t2_ifu_grant", 64'(o_ifu_ready), 64'd1);
    step();
    i_ifu_valid = 1'b0;
    mem_txn("t2b", 0, 1'b0, 32'h0010_0093, 32'h8000_0004, 1'b0, 32'h0, 4'h0);
    chk("t2_ifu_rvalid", 64'(o_ifu_rvalid), 64'd1);
    chk("t2_ifu_rdata", 64'(o_ifu_rdata), 64'h0010_0093);
    chk("t2_lsu_hold", 64'(o_lsu_rdata), 64'h1234_5678);
    step();

    // LSU store with a 3-cycle accept stall; returned data forced to 0
    i_lsu_valid = 1'b1; i_lsu_addr = 32'h8000_2000; i_lsu_we = 1'b1;
    i_lsu_wdata = 32'hCAFE_BABE; i_lsu_wmask = 4'b0011;
    step();
    i_lsu_valid = 1'b0; i_lsu_we = 1'b0; i_lsu_wdata = '0; i_lsu_wmask = '0;
    mem_txn("t3", 3, 1'b0, 32'hFFFF_FFFF, 32'h8000_2000, 1'b1, 32'hCAFE_BABE, 4'b0011);
    chk("t3_lsu_rvalid", 64'(o_lsu_rvalid), 64'd1);
    chk("t3_lsu_rdata", 64'(o_lsu_rdata), 64'd0);
    step();

    // Reset while waiting for the memory response
    i_ifu_valid = 1'b1; i_ifu_addr = 32'h8000_0008;
    step();
    i_ifu_valid = 1'b0; i_mem_ready = 1'b1;
    step();
    i_mem_ready = 1'b0; i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    chk("t4_mvalid", 64'(o_mem_valid), 64'd0);
    chk("t4_maddr", 64'(o_mem_addr), 64'd0);
    chk("t4_rdata", 64'({o_ifu_rdata, o_lsu_rdata}), 64'd0);
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0000_0055;
    step();
    i_mem_rvalid = 1'b0;
    chk("t4_late_rvalid", 64'({o_ifu_rvalid, o_lsu_rvalid}), 64'd0);
    chk("t4_late_rdata", 64'(o_ifu_rdata), 64'd0);

    // Spurious rvalid in IDLE, rvalid during REQ ignored, then a normal read
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h7777_7777;
    step();
    chk("t5_idle_rvalid", 64'({o_ifu_rvalid, o_lsu_rvalid, o_mem_valid}), 64'd0);
    i_ifu_valid = 1'b1; i_ifu_addr = 32'h8000_000C;
    #1;
    chk("t5_ready", 64'(o_ifu_ready), 64'd1);
    step();
    i_ifu_valid = 1'b0; i_mem_rvalid = 1'b0;
    mem_txn("t5", 2, 1'b1, 32'hA5A5_5A5A, 32'h8000_000C, 1'b0, 32'h0, 4'h0);
    chk("t5_ifu_rvalid", 64'(o_ifu_rvalid), 64'd1);
    chk("t5_ifu_rdata", 64'(o_ifu_rdata), 64'hA5A5_5A5A);
    step();

`ifdef YSYX_24090003_ARB_TIMEOUT_EN
    // Memory never answers: error data after TB_TIMEOUT busy cycles
    i_ifu_valid = 1'b1; i_ifu_addr = 32'h8000_0010;
    step();
    i_ifu_valid = 1'b0;
    for (int i = 0; i < int'(TB_TIMEOUT); i++) begin
      chk("t6_no_rvalid", 64'(o_ifu_rvalid), 64'd0);
      chk("t6_err_low", 64'(o_err), 64'd0);
      step();
    end
    chk("t6_ifu_rvalid", 64'(o_ifu_rvalid), 64'd1);
    chk("t6_ifu_rdata", 64'(o_ifu_rdata), 64'hDEAD_BEEF);
    chk("t6_err", 64'(o_err), 64'd1);
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h1111_1111;
    step();
    i_mem_rvalid = 1'b0;
    chk("t6_late_ignored", 64'({o_ifu_rvalid, o_lsu_rvalid}), 64'd0);
    i_lsu_valid = 1'b1; i_lsu_addr = 32'h8000_3000; i_lsu_we = 1'b0; i_lsu_wmask = 4'h0;
    step();
    i_lsu_valid = 1'b0;
    mem_txn("t6", 0, 1'b0, 32'h0BAD_F00D, 32'h8000_3000, 1'b0, 32'h0, 4'h0);
    chk("t6_lsu_rdata", 64'(o_lsu_rdata), 64'h0BAD_F00D);
    chk("t6_err_sticky", 64'(o_err), 64'd1);
    step();
`else
    chk("err_tied_low", 64'(o_err), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
